// File: rtl/mio_uart_tx.sv
// rtl/mio_uart_tx.sv - MIO bus UART transmitter: byte FIFO feeding an 8N1 serialiser.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module mio_uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        we,
    input  logic [7:0]  wdata,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        empty,
    output logic        tx_done,
    output logic [31:0] status
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            ovf;
    logic [15:0]     baud;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            baud_end;
    logic            pop;
    logic            push;
`ifdef UART_TX_PARITY_EN
    logic            parity_bit;
`endif

    assign baud_end   = (baud == 16'(CLK_DIV - 1));
    // Pops are decided from the registered empty flag, so a byte written this cycle waits one cycle.
    assign pop        = !empty && ((state == S_IDLE) || ((state == S_STOP) && baud_end));
    assign push       = we && (!full || pop);
    assign count_next = count + CW'(push) - CW'(pop);
    assign status     = {28'b0, ovf, busy, full, empty};

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state   <= S_IDLE;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            ovf     <= 1'b0;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(FIFO_DEPTH));
            empty <= (count_next == '0);
            if (we && full && !pop) ovf <= 1'b1;
            // Look one cycle ahead so the pulse lands on the last stop-bit cycle.
            tx_done <= (state == S_STOP) && (baud == 16'(CLK_DIV - 2));

            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        state <= S_START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        tx      <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= parity_bit;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_end) begin
                        baud  <= '0;
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_end) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^mem[rd_ptr];
`endif
                            state <= S_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    baud  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mio_uart_tx.sv
// tb/tb_mio_uart_tx.sv - randomized self-checking bench for mio_uart_tx against a frame-level line model.
module tb_mio_uart_tx;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int F = FRAME_BITS * CLK_DIV;

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        tx;
    logic        busy;
    logic        full;
    logic        empty;
    logic        tx_done;
    logic [31:0] status;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    logic log_tx   [8192];
    logic log_done [8192];
    logic log_busy [8192];

    mio_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .RSTN(RSTN), .we(we), .wdata(wdata), .tx(tx), .busy(busy),
        .full(full), .empty(empty), .tx_done(tx_done), .status(status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cyc < 8192) begin
            log_tx[cyc]   = tx;
            log_done[cyc] = tx_done;
            log_busy[cyc] = busy;
        end
    end

    // Line levels of one frame, bit 0 first: start, data LSB first, optional parity, stop.
    function automatic logic [FRAME_BITS-1:0] frame_levels(input logic [7:0] b);
        logic [FRAME_BITS-1:0] lv;
        lv        = '1;
        lv[0]     = 1'b0;
        lv[8:1]   = b;
`ifdef UART_TX_PARITY_EN
        lv[9]     = ^b;
`endif
        return lv;
    endfunction

    // Expected tx level for cycles N+1 .. N+len after the first write edge N.
    function automatic logic [319:0] model_tx(input byte_q_t q, input int len);
        logic [319:0]          v;
        logic [FRAME_BITS-1:0] lv;
        int                    k;
        v = '0;
        for (int i = 0; i < len; i++) v[i] = 1'b1;
        k = 0;
        foreach (q[j]) begin
            lv = frame_levels(q[j]);
            for (int b = 0; b < FRAME_BITS; b++)
                for (int c = 0; c < CLK_DIV; c++) begin
                    if (k < len) v[k] = lv[b];
                    k++;
                end
        end
        return v;
    endfunction

    function automatic logic [319:0] model_done(input int nframes, input int len);
        logic [319:0] v;
        v = '0;
        for (int i = 0; i < len; i++) v[i] = (((i + 1) % F) == 0) && (((i + 1) / F) <= nframes);
        return v;
    endfunction

    function automatic logic [319:0] grab_tx(input int n0, input int len);
        logic [319:0] v;
        v = '0;
        for (int i = 0; i < len; i++) v[i] = log_tx[n0 + 1 + i];
        return v;
    endfunction

    function automatic logic [319:0] grab_done(input int n0, input int len);
        logic [319:0] v;
        v = '0;
        for (int i = 0; i < len; i++) v[i] = log_done[n0 + 1 + i];
        return v;
    endfunction

    // Writes one byte per cycle; n0 is the edge index that samples the first write.
    task automatic write_burst(input byte_q_t q, output int n0);
        n0 = 0;
        foreach (q[i]) begin
            we    = 1'b1;
            wdata = q[i];
            @(negedge clk);
            if (i == 0) n0 = cyc;
        end
        we = 1'b0;
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        @(negedge clk);
        RSTN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (tx !== 1'b1) $display("FAIL reset_tx cycle %0d: got %b want 1", i, tx);
            else n_pass++;
            n_total++;
            if (status !== 32'h1) $display("FAIL reset_status cycle %0d: got %h want 00000001", i, status);
            else n_pass++;
            n_total++;
            if (tx_done !== 1'b0) $display("FAIL reset_tx_done cycle %0d: got %b want 0", i, tx_done);
            else n_pass++;
        end
        RSTN = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (status !== 32'h1 || tx !== 1'b1) $display("FAIL post_reset_idle: status %h tx %b want 00000001 1", status, tx);
        else n_pass++;
    endtask

    task automatic test_single(input logic [7:0] b);
        byte_q_t q;
        int      n0;
        int      len;
        q   = '{b};
        len = F + 2;
        write_burst(q, n0);
        repeat (len + 2) @(negedge clk);
        n_total++;
        if (grab_tx(n0, len) !== model_tx(q, len))
            $display("FAIL single_tx_%h: got %h want %h", b, grab_tx(n0, len), model_tx(q, len));
        else n_pass++;
        n_total++;
        if (grab_done(n0, len) !== model_done(1, len))
            $display("FAIL single_done_%h: got %h want %h", b, grab_done(n0, len), model_done(1, len));
        else n_pass++;
        n_total++;
        if (log_busy[n0 + 1] !== 1'b1 || log_busy[n0 + F + 1] !== 1'b0)
            $display("FAIL single_busy_%h: got %b,%b want 1,0", b, log_busy[n0 + 1], log_busy[n0 + F + 1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        byte_q_t q;
        int      n0;
        int      len;
        q   = '{8'hA5, 8'h3C};
        len = 2 * F + 3;
        write_burst(q, n0);
        repeat (len + 2) @(negedge clk);
        n_total++;
        if (grab_tx(n0, len) !== model_tx(q, len))
            $display("FAIL b2b_tx: got %h want %h", grab_tx(n0, len), model_tx(q, len));
        else n_pass++;
        n_total++;
        if (grab_done(n0, len) !== model_done(2, len))
            $display("FAIL b2b_done: got %h want %h", grab_done(n0, len), model_done(2, len));
        else n_pass++;
    endtask

    task automatic test_overflow();
        byte_q_t q;
        byte_q_t sent;
        int      n0;
        int      len;
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        sent = q[0:4];
        len  = 5 * F + 3;
        write_burst(q, n0);
        n_total++;
        if (full !== 1'b1 || status[3] !== 1'b1)
            $display("FAIL ovf_flags: full %b ovf %b want 1 1", full, status[3]);
        else n_pass++;
        repeat (len + 2) @(negedge clk);
        n_total++;
        if (grab_tx(n0, len) !== model_tx(sent, len))
            $display("FAIL ovf_tx: got %h want %h", grab_tx(n0, len), model_tx(sent, len));
        else n_pass++;
        n_total++;
        if (grab_done(n0, len) !== model_done(5, len))
            $display("FAIL ovf_done: got %h want %h", grab_done(n0, len), model_done(5, len));
        else n_pass++;
        n_total++;
        if (status !== 32'h9) $display("FAIL ovf_sticky: status %h want 00000009", status);
        else n_pass++;
        do_reset();
        n_total++;
        if (status !== 32'h1) $display("FAIL ovf_clear: status %h want 00000001", status);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        byte_q_t q;
        int      n0;
        int      len;
        int      t;
        logic [7:0] x;
        for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        x = 8'($urandom);
        write_burst(q, n0);
        n_total++;
        if (full !== 1'b1) $display("FAIL fullpop_prefull: full %b want 1", full);
        else n_pass++;
        t = 0;
        while (tx_done !== 1'b1 && t < 2 * F) begin
            @(negedge clk);
            t++;
        end
        n_total++;
        if (tx_done !== 1'b1 || cyc != n0 + F)
            $display("FAIL fullpop_wait: tx_done %b at cycle %0d want 1 at %0d", tx_done, cyc - n0, F);
        else n_pass++;
        we    = 1'b1;
        wdata = x;
        @(negedge clk);
        we = 1'b0;
        n_total++;
        if (full !== 1'b1 || status[3] !== 1'b0)
            $display("FAIL fullpop_flags: full %b ovf %b want 1 0", full, status[3]);
        else n_pass++;
        q.push_back(x);
        len = 6 * F + 3;
        repeat (len + 2) @(negedge clk);
        n_total++;
        if (grab_tx(n0, len) !== model_tx(q, len))
            $display("FAIL fullpop_tx: got %h want %h", grab_tx(n0, len), model_tx(q, len));
        else n_pass++;
        n_total++;
        if (grab_done(n0, len) !== model_done(6, len))
            $display("FAIL fullpop_done: got %h want %h", grab_done(n0, len), model_done(6, len));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        byte_q_t q;
        byte_q_t none;
        int      n0;
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        write_burst(q, n0);
        repeat (16) @(negedge clk);
        RSTN = 1'b0;
        @(negedge clk);
        RSTN = 1'b1;
        n_total++;
        if (tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0)
            $display("FAIL midreset_state: tx %b empty %b busy %b done %b want 1 1 0 0", tx, empty, busy, tx_done);
        else n_pass++;
        repeat (3 * F + 2) @(negedge clk);
        n_total++;
        if (grab_tx(n0, 18) !== model_tx(q, 18))
            $display("FAIL midreset_prefix: got %h want %h", grab_tx(n0, 18), model_tx(q, 18));
        else n_pass++;
        n_total++;
        if (grab_tx(n0 + 18, 3 * F) !== model_tx(none, 3 * F) || grab_done(n0 + 18, 3 * F) !== model_done(0, 3 * F))
            $display("FAIL midreset_quiet: tx %h done %h want idle line", grab_tx(n0 + 18, 3 * F), grab_done(n0 + 18, 3 * F));
        else n_pass++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single(8'h55);
        test_single(8'h07);
        for (int i = 0; i < 3; i++) test_single(8'($urandom));
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mio_uart_tx.md
# mio_uart_tx

Memory-mapped UART transmitter peripheral on the MIO bus, alongside the LED and counter peripherals. The bus decoder raises a write strobe with the CPU store data (`Peripheral_in`). This block queues bytes in a small FIFO and serialises them 8N1 on a `tx` pin. A 32-bit status word goes back into the bus read mux so software can poll before writing. `tx_done` is a frame-complete pulse usable as a CPU interrupt source.

## Interface
Parameters:
- `CLK_DIV`, 868: clock cycles per bit (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, 2..16.

Ports:
- `clk` in 1: system clock (`clk_100mhz` domain); all logic rises on its posedge.
- `RSTN` in 1: synchronous, active-low reset.
- `we` in 1: write strobe from bus decode; one byte pushed per cycle high.
- `wdata` in 8: byte to send (`Peripheral_in[7:0]`).
- `tx` out 1: serial line, idle high.
- `busy` out 1: FSM not in IDLE.
- `full` out 1: FIFO holds `FIFO_DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries.
- `tx_done` out 1: one-cycle pulse at the end of each stop bit.
- `status` out 32: `{28'b0, ovf, busy, full, empty}`.

## Operation
- FIFO:
  - Circular buffer with read/write pointers plus a count register of width clog2(FIFO_DEPTH)+1.
  - Push when `we && (!full || pop)`. The pop in the same cycle frees a slot, so the push is accepted.
  - `we && full && !pop` drops the byte and sets sticky `ovf`. Only reset clears `ovf`.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE:
  - `tx`=1.
  - If `!empty`, pop the head into an 8-bit shift register and go to START.
  - The pop decision uses registered `empty`. A byte written in the same cycle is not popped until the next cycle.
- START: `tx`=0 for `CLK_DIV` cycles, then DATA.
- DATA:
  - `tx` = shift[0], LSB first.
  - Each `CLK_DIV` cycles the register shifts right and a 3-bit bit counter increments.
  - After bit 7, go to STOP (or PARITY with the macro).
- STOP: `tx`=1 for `CLK_DIV` cycles. On the last cycle:
  - pulse `tx_done`;
  - if `!empty`, pop and go to START directly (no idle gap between frames);
  - otherwise go to IDLE.
- Baud counter:
  - 16 bits; counts 0..CLK_DIV-1 while not IDLE.
  - Resets to 0 on every state change and is held at 0 in IDLE.
- `tx` is driven from a flop, so there is no combinational glitch on the pin.
- Reset (`RSTN`=0 at a posedge), any state including mid-frame:
  - next-cycle values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `tx_done`=0, `ovf`=0, `status`=32'h1;
  - FIFO flushed, state IDLE, counters 0.

## Timing
- Write at edge N into an empty FIFO with the FSM idle:
  - `empty` falls after edge N;
  - pop and START at edge N+1, so `tx` falls after edge N+1;
  - `busy` rises after edge N+1.
- Frame length: exactly 10·CLK_DIV cycles (11·CLK_DIV with parity), measured from the `tx` fall to the end of the stop bit.
- `tx_done` is high during the final cycle of STOP only.
- `status`, `full` and `empty` are registered. They reflect pushes and pops one cycle after the edge that performed them.
- Consecutive queued bytes: the START of byte k+1 begins on the cycle immediately after `tx_done` of byte k.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - `tx` = even parity (XOR of the 8 data bits) for `CLK_DIV` cycles.
  - Frame = 11·CLK_DIV.
- Not defined: no PARITY state, 8N1 frames of 10·CLK_DIV. PARITY logic and its state encoding are absent.

## Test plan
Benches use `CLK_DIV`=4 and `FIFO_DEPTH`=4.
- Reset:
  - Stimulus: hold `RSTN`=0 for 3 cycles, then release.
  - Required: `tx`=1, `status`=32'h1, `tx_done`=0 throughout.
- Single byte:
  - Stimulus: write 8'h55 at edge N.
  - Required: `tx`=0 on cycles N+1..N+4, then 1,0,1,0,1,0,1,0 each for 4 cycles, then 1 for 4 cycles.
  - Required: `tx_done` high only on cycle N+40; `busy` low at N+41.
- Back-to-back:
  - Stimulus: write 8'hA5 then 8'h3C on consecutive cycles.
  - Required: two frames with no idle cycle between them; `tx_done` pulses 40 cycles apart.
- Overflow:
  - Stimulus: write 6 bytes on consecutive cycles from idle.
  - Required: byte 1 popped at the cycle after its write, 4 buffered; byte 6 dropped; `ovf`=1 and `full`=1.
  - Required: the line carries exactly bytes 1–5, in order.
- Full with simultaneous pop:
  - Stimulus: FIFO full; assert `we` on the STOP-last cycle.
  - Required: byte accepted, `ovf` stays 0, `full` remains 1.
- Reset mid-frame:
  - Stimulus: assert `RSTN`=0 in the middle of data bit 3.
  - Required: `tx`=1 the next cycle and `empty`=1; no `tx_done`. With `UART_TX_PARITY_EN` defined, sending 8'h07 shows parity bit 1 and an 11-bit-period frame.
